// File: rtl/exc_entry_ctrl.sv
// Exception-entry sequencer: prioritises requests and walks RegFile_plus through SPSR save, LR write and PC load.
// Optional macro HIGH_VEC_EN adds the hivec input that relocates the vector base to 32'hFFFF0000.
module exc_entry_ctrl #(
  parameter logic [31:0] VEC_BASE      = 32'h0000_0000,
  parameter logic [31:0] DABT_LINK_OFS = 32'd8,
  parameter logic [31:0] STD_LINK_OFS  = 32'd4
) (
  input  logic        clk,
  input  logic        Rst,
  input  logic [5:0]  exc_req,
  input  logic [31:0] cur_PC,
  input  logic [3:0]  flags_in,
  input  logic        mode_we,
  input  logic [6:0]  mode_wdata,
`ifdef HIGH_VEC_EN
  input  logic        hivec,
`endif
  output logic [4:0]  M,
  output logic        I_bit,
  output logic        F_bit,
  output logic        Write_Reg,
  output logic [3:0]  W_Addr,
  output logic [31:0] W_Data,
  output logic        Write_PC,
  output logic [31:0] PC_New,
  output logic        spsr_we,
  output logic [31:0] spsr_data,
  output logic        busy,
  output logic        done,
  output logic [2:0]  exc_taken
);

  typedef enum logic [2:0] {IDLE, SAVE, LINK, VECTOR, DONE} state_t;

  state_t      state, state_n;
  logic [2:0]  exc_q, exc_n;
  logic [31:0] pc_q, pc_n;
  logic [31:0] cpsr_q, cpsr_n;
  logic [31:0] base_q, base_n;

  logic [4:0]  m_n;
  logic        i_n, f_n;
  logic        write_reg_n, write_pc_n, spsr_we_n, busy_n, done_n;
  logic [3:0]  w_addr_n;
  logic [31:0] w_data_n, pc_new_n, spsr_data_n;
  logic [2:0]  exc_taken_n;

  logic [5:0]  eff;
  logic [2:0]  win;
  logic [4:0]  new_mode;
  logic [31:0] vec_ofs, lr_ofs, base_sel;

  // Masked requests; the lowest set bit is the highest priority (code = bit index + 1).
  always_comb begin
    eff    = exc_req;
    eff[1] = exc_req[1] & ~F_bit;
    eff[2] = exc_req[2] & ~I_bit;
    win    = 3'd0;
    for (int k = 5; k >= 0; k--) begin
      if (eff[k]) win = 3'(k + 1);
    end
  end

  always_comb begin
    new_mode = 5'b10011;
    vec_ofs  = 32'h08;
    lr_ofs   = STD_LINK_OFS;
    case (exc_q)
      3'd1: begin new_mode = 5'b10111; vec_ofs = 32'h10; lr_ofs = DABT_LINK_OFS; end
      3'd2: begin new_mode = 5'b10001; vec_ofs = 32'h1C; end
      3'd3: begin new_mode = 5'b10010; vec_ofs = 32'h18; end
      3'd4: begin new_mode = 5'b10111; vec_ofs = 32'h0C; end
      3'd5: begin new_mode = 5'b11011; vec_ofs = 32'h04; end
      default: ;
    endcase
  end

`ifdef HIGH_VEC_EN
  assign base_sel = hivec ? 32'hFFFF_0000 : VEC_BASE;
`else
  assign base_sel = VEC_BASE;
`endif

  // Outputs are registered from the current state, so each phase's strobe appears one edge after entry.
  always_comb begin
    state_n     = state;
    exc_n       = exc_q;
    pc_n        = pc_q;
    cpsr_n      = cpsr_q;
    base_n      = base_q;
    m_n         = M;
    i_n         = I_bit;
    f_n         = F_bit;
    write_reg_n = 1'b0;
    write_pc_n  = 1'b0;
    spsr_we_n   = 1'b0;
    busy_n      = 1'b0;
    done_n      = 1'b0;
    w_addr_n    = W_Addr;
    w_data_n    = W_Data;
    pc_new_n    = PC_New;
    spsr_data_n = spsr_data;
    exc_taken_n = 3'd0;
    case (state)
      IDLE: begin
        if (win != 3'd0) begin
          exc_n   = win;
          pc_n    = cur_PC;
          cpsr_n  = {flags_in, 20'b0, I_bit, F_bit, 1'b0, M};
          base_n  = base_sel;
          state_n = SAVE;
        end else if (mode_we) begin
          {i_n, f_n, m_n} = mode_wdata;
        end
      end
      SAVE: begin
        m_n         = new_mode;
        i_n         = 1'b1;
        if (exc_q == 3'd2) f_n = 1'b1;
        spsr_we_n   = 1'b1;
        spsr_data_n = cpsr_q;
        busy_n      = 1'b1;
        exc_taken_n = exc_q;
        state_n     = LINK;
      end
      LINK: begin
        write_reg_n = 1'b1;
        w_addr_n    = 4'd14;
        w_data_n    = pc_q + lr_ofs;
        busy_n      = 1'b1;
        exc_taken_n = exc_q;
        state_n     = VECTOR;
      end
      VECTOR: begin
        write_pc_n  = 1'b1;
        pc_new_n    = base_q + vec_ofs;
        busy_n      = 1'b1;
        exc_taken_n = exc_q;
        state_n     = DONE;
      end
      DONE: begin
        done_n      = 1'b1;
        busy_n      = 1'b1;
        exc_taken_n = exc_q;
        state_n     = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Rst) begin
      state     <= IDLE;
      exc_q     <= 3'd0;
      pc_q      <= 32'd0;
      cpsr_q    <= 32'd0;
      base_q    <= 32'd0;
      M         <= 5'b10011;
      I_bit     <= 1'b1;
      F_bit     <= 1'b1;
      Write_Reg <= 1'b0;
      Write_PC  <= 1'b0;
      spsr_we   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      W_Addr    <= 4'd0;
      W_Data    <= 32'd0;
      PC_New    <= 32'd0;
      spsr_data <= 32'd0;
      exc_taken <= 3'd0;
    end else begin
      state     <= state_n;
      exc_q     <= exc_n;
      pc_q      <= pc_n;
      cpsr_q    <= cpsr_n;
      base_q    <= base_n;
      M         <= m_n;
      I_bit     <= i_n;
      F_bit     <= f_n;
      Write_Reg <= write_reg_n;
      Write_PC  <= write_pc_n;
      spsr_we   <= spsr_we_n;
      busy      <= busy_n;
      done      <= done_n;
      W_Addr    <= w_addr_n;
      W_Data    <= w_data_n;
      PC_New    <= pc_new_n;
      spsr_data <= spsr_data_n;
      exc_taken <= exc_taken_n;
    end
  end

endmodule
